// File: rtl/full_subtractor_seq_if.sv
// Interface bundling the data/valid signals of full_subtractor_seq.
// master: drives operands and samples results (bench or upstream slice).
// slave : the subtractor itself.
interface full_subtractor_seq_if;
  logic in_valid;
  logic a;
  logic b;
  logic cin;
  logic diff;
  logic borrow;
  logic out_valid;
  logic chk_err;

  modport master (
    output in_valid, a, b, cin,
    input  diff, borrow, out_valid, chk_err
  );

  modport slave (
    input  in_valid, a, b, cin,
    output diff, borrow, out_valid, chk_err
  );
endinterface

// File: rtl/full_subtractor_seq.sv
// Registered 1-bit full subtractor: {borrow,diff} = a - b - cin, one cycle latency.
// Optional build macro FULL_SUB_CHECK_EN adds a registered arithmetic reference
// path and a sticky chk_err flag; without it chk_err is tied low.
//
// Handshake: valid-only, no ready. Operands are taken on every rising edge
// where in_valid=1 and the result appears on diff/borrow with out_valid=1 for
// exactly the following cycle. Edges with in_valid=0 leave diff/borrow unchanged
// and drop out_valid, so operands are ignored (X-safe) while in_valid is low.
module full_subtractor_seq #(
  parameter logic RESET_DIFF   = 1'b0,
  parameter logic RESET_BORROW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  full_subtractor_seq_if.slave bus
);

  logic diff_q;
  logic borrow_q;
  logic out_valid_q;
  logic diff_next;
  logic borrow_next;

  // Boolean full-subtract of the current operands.
  always_comb begin
    diff_next   = bus.a ^ bus.b ^ bus.cin;
    borrow_next = (~bus.a & bus.b) | (~(bus.a ^ bus.b) & bus.cin);
  end

  // Result register: load on valid, hold otherwise; out_valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q      <= RESET_DIFF;
      borrow_q    <= RESET_BORROW;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        diff_q   <= diff_next;
        borrow_q <= borrow_next;
      end
    end
  end

  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.out_valid = out_valid_q;

`ifdef FULL_SUB_CHECK_EN
  logic [1:0] ref_q;
  logic       chk_err_q;

  // Independent reference: 2-bit arithmetic subtract, registered alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= {RESET_BORROW, RESET_DIFF};
    end else if (bus.in_valid) begin
      ref_q <= {1'b0, bus.a} - {1'b0, bus.b} - {1'b0, bus.cin};
    end
  end

  // Sticky error: set on any presented result that disagrees with the reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if (out_valid_q && ({borrow_q, diff_q} != ref_q)) begin
      chk_err_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_subtractor_seq.sv
// Self-checking bench for full_subtractor_seq: arithmetic reference model with
// an expected-result queue, per-cycle compare, directed literal checks, random traffic.
module tb_full_subtractor_seq;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   model_en = 1'b1;

  full_subtractor_seq_if u_if ();
  full_subtractor_seq_if c0_if ();
  full_subtractor_seq_if c1_if ();

  full_subtractor_seq u_dut (.clk(clk), .rst(rst), .bus(u_if));
  full_subtractor_seq u_c0  (.clk(clk), .rst(rst), .bus(c0_if));
  full_subtractor_seq u_c1  (.clk(clk), .rst(rst), .bus(c1_if));

  // Ripple-borrow chain: upper slice takes the lower slice's registered borrow.
  assign c1_if.cin = c0_if.borrow;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];
  logic [1:0] exp_hold;
  logic       exp_valid;
  logic [1:0] r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_hold  = 2'b00;
    end else if (u_if.in_valid === 1'b1) begin
      r = {1'b0, u_if.a} - {1'b0, u_if.b} - {1'b0, u_if.cin};
      exp_q.push_back(r);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst && model_en) begin
      chk("out_valid", {1'b0, u_if.out_valid}, {1'b0, exp_valid});
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_empty: got none expected one entry at %0t", $time);
        end else begin
          exp_hold = exp_q.pop_front();
        end
      end
      chk("result", {u_if.borrow, u_if.diff}, exp_hold);
      chk("chk_err", {1'b0, u_if.chk_err}, 2'b00);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [2:0] abc);
    @(negedge clk);
    u_if.in_valid = v;
    u_if.a        = abc[2];
    u_if.b        = abc[1];
    u_if.cin      = abc[0];
  endtask

  task automatic expect_out(input string name, input logic [1:0] bd, input logic v);
    @(posedge clk);
    #1;
    chk({name, "_bd"}, {u_if.borrow, u_if.diff}, bd);
    chk({name, "_vld"}, {1'b0, u_if.out_valid}, {1'b0, v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.a = 1'b1;
    u_if.b = 1'b1;
    u_if.cin = 1'b1;
    c0_if.in_valid = 1'b0;
    c0_if.a = 1'b0;
    c0_if.b = 1'b0;
    c0_if.cin = 1'b0;
    c1_if.in_valid = 1'b0;
    c1_if.a = 1'b0;
    c1_if.b = 1'b0;

    // Reset values before any clock edge.
    #1;
    chk("rst_bd", {u_if.borrow, u_if.diff}, 2'b00);
    chk("rst_vld", {1'b0, u_if.out_valid}, 2'b00);
    chk("rst_chk", {1'b0, u_if.chk_err}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    rst = 1'b0;

    // Exhaustive sweep, one combination per cycle, with a literal pin on row 011.
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i));
    drive(1'b0, 3'b000);
    drive(1'b1, 3'b011);
    expect_out("row011", 2'b10, 1'b1);

    // Hold: valid 100 then invalid with different operands.
    drive(1'b1, 3'b100);
    expect_out("hold_load", 2'b01, 1'b1);
    drive(1'b0, 3'b010);
    expect_out("hold_keep", 2'b01, 1'b0);

    // X on operands while idle must not reach the outputs.
    drive(1'b0, 3'bxxx);
    expect_out("x_idle", 2'b01, 1'b0);

    // Mid-stream reset between the 2nd and 3rd valid edges.
    drive(1'b1, 3'b001);
    drive(1'b1, 3'b010);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_bd", {u_if.borrow, u_if.diff}, 2'b00);
    chk("midrst_vld", {1'b0, u_if.out_valid}, 2'b00);
    #1;
    rst = 1'b0;
    drive(1'b1, 3'b111);
    expect_out("after_rst", 2'b11, 1'b1);

    // Random traffic, including X operands on idle cycles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 3'bxxx);
      else drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    drive(1'b0, 3'b000);

    // Two-slice chain: 2'b01 - 2'b10, upper slice one cycle behind.
    @(negedge clk);
    c0_if.in_valid = 1'b1;
    c0_if.a = 1'b1;
    c0_if.b = 1'b0;
    c0_if.cin = 1'b0;
    @(negedge clk);
    c0_if.in_valid = 1'b0;
    c1_if.in_valid = 1'b1;
    c1_if.a = 1'b0;
    c1_if.b = 1'b1;
    @(posedge clk);
    #1;
    chk("chain_d0", {1'b0, c0_if.diff}, 2'b01);
    chk("chain_d1", {c1_if.borrow, c1_if.diff}, 2'b11);
    chk("chain_vld", {c0_if.out_valid, c1_if.out_valid}, 2'b01);
    @(negedge clk);
    c1_if.in_valid = 1'b0;

`ifdef FULL_SUB_CHECK_EN
    // Corrupt one presented result and confirm the sticky flag.
    model_en = 1'b0;
    drive(1'b1, 3'b100);
    @(posedge clk);
    #1;
    force u_dut.diff_q = 1'b0;
    drive(1'b0, 3'b000);
    @(posedge clk);
    #1;
    release u_dut.diff_q;
    chk("chk_set", {1'b0, u_if.chk_err}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("chk_sticky", {1'b0, u_if.chk_err}, 2'b01);
    rst = 1'b1;
    #1;
    chk("chk_clr", {1'b0, u_if.chk_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
